// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the fetch/LSB memory controller.
// Pure declarations: no timing.
// No flow control of its own.
package mem_ctrl_pkg;

  localparam int LINE_BYTES = 64;
  localparam int ROW_W      = 8 * LINE_BYTES;
  // Counter must reach LINE_BYTES itself (one extra cycle to capture the last byte).
  localparam int CNT_W      = $clog2(LINE_BYTES) + 1;

  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    STORE,
    DONE
  } state_e;

  // Byte count for an LSB size code; the illegal code 3 is treated as a word.
  function automatic logic [CNT_W-1:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    return CNT_W'(1);
      SZ_H:    return CNT_W'(2);
      default: return CNT_W'(4);
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle of RAM port, i-fetch miss and LSB request signals.
// No logic, no latency.
// Requesters hold their level until the matching done pulse.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  // byte-wide RAM/IO port
  logic [7:0]       mem_din;
  logic [7:0]       mem_dout;
  logic [31:0]      mem_a;
  logic             mem_wr;
  logic             io_buffer_full;
  // instruction-fetch miss
  logic [31:0]      missing_PC;
  logic             missing_config;
  logic [ROW_W-1:0] return_row;
  logic             return_config;
  // load/store buffer
  logic             lsb_req;
  logic             lsb_wr;
  logic [31:0]      lsb_addr;
  logic [1:0]       lsb_size;
  logic [31:0]      lsb_wdata;
  logic [31:0]      lsb_rdata;
  logic             lsb_done;
  logic             rollback_config;

  modport slave (
    input  mem_din, io_buffer_full,
    output mem_dout, mem_a, mem_wr,
    input  missing_PC, missing_config,
    output return_row, return_config,
    input  lsb_req, lsb_wr, lsb_addr, lsb_size, lsb_wdata, rollback_config,
    output lsb_rdata, lsb_done
  );

  modport master (
    output mem_din, io_buffer_full,
    input  mem_dout, mem_a, mem_wr,
    output missing_PC, missing_config,
    input  return_row, return_config,
    output lsb_req, lsb_wr, lsb_addr, lsb_size, lsb_wdata, rollback_config,
    input  lsb_rdata, lsb_done
  );

endinterface

// File: rtl/mem_ctrl.sv
// Serialises i-fetch row fills and LSB loads/stores onto one byte-wide RAM port.
// Fetch: done pulse 66 cycles after accept; load n bytes: n+2; store n bytes: n+1 plus IO stalls.
// Requests are levels held until done; IO stores wait on io_buffer_full; rdy=0 freezes everything.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input logic     clk,
  input logic     rst,
  input logic     rdy,
  mem_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;      // address currently on the RAM port
  logic [CNT_W-1:0] cnt_q, cnt_d;        // bytes issued so far
  logic [CNT_W-1:0] len_q, len_d;        // bytes in this transfer
  logic             fetch_q, fetch_d;    // selects which done pulse DONE raises
  logic [ROW_W-1:0] row_q, row_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      wdata_q, wdata_d;    // shifted right as bytes go out

  logic             issue;
  logic             io_stall;
  logic [1:0]       cap_idx;
  logic             unused_pc_bits;

  // Row base is line-aligned, so the low PC bits never matter.
  assign unused_pc_bits = ^bus.missing_PC[5:0];

  assign io_stall = (addr_q >= IO_BASE) && bus.io_buffer_full;
  // Read data lags the address by one cycle, so the byte arriving now is the previous index.
  assign cap_idx  = cnt_q[1:0] - 2'd1;

  // Next-state and datapath: accept in IDLE, then one byte per cycle through a single counter.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    fetch_d = fetch_q;
    row_d   = row_q;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    issue   = 1'b0;

    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (bus.lsb_req) begin
            state_d = bus.lsb_wr ? STORE : LOAD;
            fetch_d = 1'b0;
            addr_d  = bus.lsb_addr;
            len_d   = size_bytes(bus.lsb_size);
            cnt_d   = '0;
            wdata_d = bus.lsb_wdata;
            rdata_d = '0;
          end else if (bus.missing_config) begin
            state_d = FETCH;
            fetch_d = 1'b1;
            addr_d  = {bus.missing_PC[31:6], 6'b0};
            len_d   = CNT_W'(LINE_BYTES);
            cnt_d   = '0;
          end
        end

        FETCH, LOAD: begin
          addr_d = addr_q + 32'd1;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q != '0) begin
            if (state_q == FETCH) row_d = {bus.mem_din, row_q[ROW_W-1:8]};
            else                  rdata_d[{cap_idx, 3'b000} +: 8] = bus.mem_din;
          end
          if (cnt_q == len_q) state_d = DONE;
          // A flush only kills loads; fills and stores always run to completion.
          if (state_q == LOAD && bus.rollback_config) state_d = IDLE;
        end

        STORE: begin
          if (!io_stall) begin
            issue   = 1'b1;
            addr_d  = addr_q + 32'd1;
            cnt_d   = cnt_q + CNT_W'(1);
            wdata_d = {8'h00, wdata_q[31:8]};
            if (cnt_q == len_q - CNT_W'(1)) state_d = DONE;
          end
        end

        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register; synchronous reset drops any pending done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      fetch_q <= 1'b0;
      row_q   <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      fetch_q <= fetch_d;
      row_q   <= row_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.mem_a         = addr_q;
  assign bus.mem_dout      = wdata_q[7:0];
  assign bus.mem_wr        = issue;
  assign bus.return_row    = row_q;
  assign bus.lsb_rdata     = rdata_q;
  assign bus.return_config = rdy && (state_q == DONE) && fetch_q;
  assign bus.lsb_done      = rdy && (state_q == DONE) && !fetch_q;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Responder side of the instruction-fetch miss interface; also serves the load/store buffer (LSB).
- Owns the single byte-wide RAM/IO port and serialises requests onto it.
- Fetch misses return a full 64-byte cache row as 512 bits.
- LSB requests (1/2/4-byte load or store) return or commit one little-endian word.

Parameters:
- LINE_BYTES, 64, bytes per i-cache row; return_row width is 8*LINE_BYTES.
- IO_BASE, 32'h00030000, addresses >= IO_BASE are IO and subject to io_buffer_full.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; when low, all state holds and mem_wr is forced 0.
- mem_din  in  8  RAM read data; valid one cycle after mem_a.
- mem_dout  out  8  RAM write data.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  1 = write this cycle.
- io_buffer_full  in  1  IO sink cannot accept a write.
- missing_PC  in  32  fetch miss address; bits [5:0] are ignored.
- missing_config  in  1  fetch miss request level; held until return_config.
- return_row  out  512  filled row; byte k at bits [8k+7:8k].
- return_config  out  1  one-cycle pulse; return_row valid this cycle.
- lsb_req  in  1  LSB request level; held until lsb_done.
- lsb_wr  in  1  1 = store.
- lsb_addr  in  32  byte address.
- lsb_size  in  2  0 = 1 B, 1 = 2 B, 2 = 4 B; 3 is illegal.
- lsb_wdata  in  32  store data, little-endian, low bytes used.
- lsb_rdata  out  32  load data, zero-extended; the LSB does sign extension.
- lsb_done  out  1  one-cycle pulse: load data valid or store committed.
- rollback_config  in  1  ROB flush.

Behaviour:
- Reset values: mem_a=0, mem_dout=0, mem_wr=0, return_config=0, return_row=0, lsb_done=0, lsb_rdata=0, state=IDLE, counters=0.
- FSM states: IDLE, FETCH, LOAD, STORE, DONE.
- IDLE: if lsb_req is high, accept the LSB request (priority over fetch) and go to LOAD or STORE. Else if missing_config is high, go to FETCH with base = {missing_PC[31:6], 6'b0}. Request fields are latched at the accept edge (E0).
- Read timing, FETCH and LOAD:
  - Byte i address is driven in cycle i+1 after E0.
  - Byte i is captured from mem_din at the end of cycle i+2.
  - FETCH: addresses base+0..63 in cycles 1..64; return_config=1 in cycle 66; total 66 cycles.
  - LOAD, n bytes: return lsb_done=1 in cycle n+2 (4 B: addresses cycles 1–4, done cycle 6).
- STORE: byte i drives mem_a=addr+i, mem_dout=wdata[8i+7:8i], mem_wr=1 for one cycle; lsb_done pulses the cycle after the last byte (4 B: done in cycle 5).
- IO stall: a store byte whose address >= IO_BASE is not issued while io_buffer_full=1. mem_wr stays 0 and the byte counter holds; the byte issues in the first cycle io_buffer_full=0. Loads ignore io_buffer_full.
- DONE: outputs the pulse for exactly one cycle, accepts no new request, then IDLE. This lets the requester drop its level at the same edge and prevents double acceptance.
- Rollback:
  - rollback_config=1 during LOAD aborts it: next state IDLE, no lsb_done.
  - STORE and FETCH are not aborted; the fetch side keeps its request across rollback.
  - Rollback in IDLE has no effect.
- Idle bus: mem_wr=0 whenever not issuing a store byte; mem_a is don't-care.
- Address arithmetic is 32-bit wrapping; unaligned LSB accesses are legal, bytes issued in order.
- A new request is accepted no earlier than the cycle after DONE; back-to-back requests cost 1 idle cycle.
- rst mid-operation: immediate return to reset values; a pending return pulse is lost.

Decomposition:
- Shared package holds:
  - state enum (IDLE, FETCH, LOAD, STORE, DONE);
  - size encodings SZ_B=0, SZ_H=1, SZ_W=2;
  - LINE_BYTES;
  - IO_BASE.
- No sub-module is needed.
- A byte-counter/shift-assembler helper is optional but is kept inline, since one counter serves all three transfer states.

Test Plan:
- Fetch fill: missing_PC=0x1044 with RAM[0x1040+k]=k, hold request -> addresses 0x1040..0x107F in cycles 1–64; return_config in cycle 66 with return_row byte k = k; single pulse.
- Word load: lsb_addr=0x200, size 2, RAM=11 22 33 44 -> lsb_rdata=0x44332211, lsb_done in cycle 6; a half load at 0x201 returns 0x00003322.
- Contention: lsb_req and missing_config rise the same cycle -> load served first, fetch accepted the cycle after DONE, both complete.
- IO store: lsb_addr=0x30000, size 0, data 0x41, io_buffer_full=1 for 3 cycles -> mem_wr=0 during the stall, then one write of 0x41, lsb_done the cycle after.
- Rollback: rollback_config in cycle 3 of a 4-byte load -> no lsb_done, IDLE next cycle. Same pulse during a store -> all 4 bytes written, lsb_done issued.
- Reset mid-fill at cycle 30 -> return_config never pulses; outputs at reset values; a fresh request completes normally.
